// File: rtl/isbus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : isbus_pkg
// Brief    : Shared timing constants, FSM states and word-select field type.
// Revision : 1.0
// ============================================================================
package isbus_pkg;

    localparam int c_word_times = 56;
    localparam int c_sync_start = 45;
    localparam int c_digit_w    = 4;
    localparam int c_inst_w     = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic                 en;
        logic [c_digit_w-1:0] first;
        logic [c_digit_w-1:0] last;
    } ws_field_t;

    localparam ws_field_t c_ws_off = '{en: 1'b0, first: '0, last: '0};

endpackage
`default_nettype wire

// File: rtl/isbus_ws_gen.sv
`default_nettype none
// ============================================================================
// Module   : isbus_ws_gen
// Brief    : Word-select decode; high while the bit-time lies in the digit span.
// Revision : 1.0
// ============================================================================
module isbus_ws_gen
    import isbus_pkg::*;
(
    input  logic [5:0]           i_cnt,
    input  logic                 i_en,
    input  logic [c_digit_w-1:0] i_first,
    input  logic [c_digit_w-1:0] i_last,
    output logic                 o_ws
);

    logic [5:0] w_lo;
    logic [5:0] w_hi;

    // A reversed field (first > last) yields an empty range on its own.
    assign w_lo = {i_first, 2'b00};
    assign w_hi = {i_last, 2'b11};
    assign o_ws = i_en && (i_cnt >= w_lo) && (i_cnt <= w_hi);

endmodule
`default_nettype wire

// File: rtl/isbus_tx.sv
`default_nettype none
// ============================================================================
// Module   : isbus_tx
// Brief    : Instruction serial-bus transmitter: word-cycle timing, serial
//            instruction window, word-select generation and fetch address.
// Revision : 1.0
// ============================================================================
module isbus_tx
    import isbus_pkg::*;
#(
    parameter int WORD_TIMES = c_word_times,
    parameter int SYNC_START = c_sync_start
) (
    input  logic                 cph2,
    input  logic                 rstb,
    input  logic                 run,
    input  logic [c_inst_w-1:0]  inst_data,
    input  logic                 inst_valid,
    input  logic [c_digit_w-1:0] ws_first,
    input  logic [c_digit_w-1:0] ws_last,
    output logic                 inst_ready,
    output logic [7:0]           adr,
    input  logic                 adr_load,
    input  logic [7:0]           adr_in,
    output logic                 is,
    output logic                 sync,
    output logic                 ws,
    output logic [5:0]           sys_cnt,
    output logic                 underrun
);

    localparam logic [5:0] c_cnt_last = 6'(WORD_TIMES - 1);
    localparam logic [5:0] c_sample   = 6'(SYNC_START - 1);
    localparam logic [5:0] c_sync_lo  = 6'(SYNC_START);
    localparam logic [5:0] c_sync_hi  = 6'(SYNC_START + c_inst_w - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [5:0]          r_cnt;
    logic [7:0]          r_adr;
    logic [c_inst_w-1:0] r_word;
    ws_field_t           r_ws_pend;
    ws_field_t           r_ws_act;
    logic                r_underrun;

    logic                w_active;
    logic                w_cnt_last;
    logic                w_sample;
    logic                w_in_win;
    logic [5:0]          w_bit_idx;
    logic [c_inst_w-1:0] w_word_sh;
    logic                w_ws_raw;

    assign w_active   = (r_state != ST_IDLE);
    assign w_cnt_last = (r_cnt == c_cnt_last);
    assign w_sample   = (r_state == ST_RUN) && (r_cnt == c_sample);
    assign w_in_win   = (r_cnt >= c_sync_lo) && (r_cnt <= c_sync_hi);
    assign w_bit_idx  = r_cnt - c_sync_lo;
    assign w_word_sh  = r_word >> w_bit_idx;

    always_ff @(posedge cph2 or negedge rstb) begin
        if (!rstb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (run) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!run) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Re-asserting run resumes without disturbing the bit-time count.
                if (run)             w_state_nxt = ST_RUN;
                else if (w_cnt_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        inst_ready = w_sample && inst_valid;
        sync       = 1'b0;
        is         = 1'b0;
        ws         = 1'b0;
        if (w_active) begin
            sync = w_in_win;
            is   = w_in_win && w_word_sh[0];
            ws   = w_ws_raw;
        end
    end

    always_ff @(posedge cph2 or negedge rstb) begin
        if (!rstb) begin
            r_cnt      <= '0;
            r_adr      <= '0;
            r_word     <= '0;
            r_ws_pend  <= c_ws_off;
            r_ws_act   <= c_ws_off;
            r_underrun <= 1'b0;
        end else begin
            if (!w_active || w_cnt_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 6'd1;
            end

            // A missed slot sends a NOP and leaves the next word-select disabled.
            if (w_sample) begin
                if (inst_valid) begin
                    r_word    <= inst_data;
                    r_ws_pend <= '{en: 1'b1, first: ws_first, last: ws_last};
                end else begin
                    r_word     <= '0;
                    r_ws_pend  <= c_ws_off;
                    r_underrun <= 1'b1;
                end
            end

            if (w_active && w_cnt_last) begin
                r_ws_act <= r_ws_pend;
            end

            if ((r_state == ST_RUN) && w_cnt_last) begin
                r_adr <= adr_load ? adr_in : r_adr + 8'd1;
            end
        end
    end

    isbus_ws_gen u_ws_gen (
        .i_cnt   (r_cnt),
        .i_en    (r_ws_act.en),
        .i_first (r_ws_act.first),
        .i_last  (r_ws_act.last),
        .o_ws    (w_ws_raw)
    );

    assign sys_cnt  = r_cnt;
    assign adr      = r_adr;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_isbus_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_isbus_tx
// Brief    : Self-checking bench for isbus_tx against a word-cycle level model.
// Revision : 1.0
// ============================================================================
module tb_isbus_tx;

    localparam int WT = 56;
    localparam int SS = 45;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic       cph2 = 1'b0;
    logic       rstb;
    logic       run;
    logic [9:0] inst_data;
    logic       inst_valid;
    logic [3:0] ws_first;
    logic [3:0] ws_last;
    logic       inst_ready;
    logic [7:0] adr;
    logic       adr_load;
    logic [7:0] adr_in;
    logic       is;
    logic       sync;
    logic       ws;
    logic [5:0] sys_cnt;
    logic       underrun;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    isbus_tx dut (
        .cph2       (cph2),
        .rstb       (rstb),
        .run        (run),
        .inst_data  (inst_data),
        .inst_valid (inst_valid),
        .ws_first   (ws_first),
        .ws_last    (ws_last),
        .inst_ready (inst_ready),
        .adr        (adr),
        .adr_load   (adr_load),
        .adr_in     (adr_in),
        .is         (is),
        .sync       (sync),
        .ws         (ws),
        .sys_cnt    (sys_cnt),
        .underrun   (underrun)
    );

    always #5 cph2 = ~cph2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one mode, bit-time, address, current word and the
    // word-select span active now / armed for the next word cycle.
    int         m_mode, m_cnt, m_adr;
    logic [9:0] m_word;
    bit         m_under, m_last;
    int         cur_en, cur_f, cur_l, nxt_en, nxt_f, nxt_l;

    always @(posedge cph2 or negedge rstb) begin
        if (!rstb) begin
            m_mode = M_IDLE; m_cnt = 0; m_adr = 0; m_word = '0; m_under = 0;
            cur_en = 0; cur_f = 0; cur_l = 0; nxt_en = 0; nxt_f = 0; nxt_l = 0;
        end else if (m_mode == M_IDLE) begin
            if (run) m_mode = M_RUN;
        end else begin
            m_last = (m_cnt == WT - 1);
            if (m_mode == M_RUN && m_cnt == SS - 1) begin
                if (inst_valid) begin
                    m_word = inst_data; nxt_en = 1; nxt_f = ws_first; nxt_l = ws_last;
                end else begin
                    m_word = '0; nxt_en = 0; m_under = 1;
                end
            end
            if (m_mode == M_RUN && m_last)
                m_adr = adr_load ? int'(adr_in) : (m_adr + 1) % 256;
            if (m_last) begin
                cur_en = nxt_en; cur_f = nxt_f; cur_l = nxt_l;
            end
            m_cnt = (m_cnt + 1) % WT;
            if (m_mode == M_RUN) begin
                if (!run) m_mode = M_DRAIN;
            end else if (run) begin
                m_mode = M_RUN;
            end else if (m_last) begin
                m_mode = M_IDLE;
            end
        end
    end

    bit e_act, e_sync, e_is, e_ws, e_rdy;

    always @(negedge cph2) begin
        if (chk_en) begin
            e_act  = (m_mode != M_IDLE);
            e_sync = e_act && m_cnt >= SS && m_cnt <= SS + 9;
            e_is   = 0;
            if (e_sync) e_is = m_word[m_cnt - SS];
            e_ws   = e_act && cur_en != 0 && (m_cnt / 4) >= cur_f && (m_cnt / 4) <= cur_l;
            e_rdy  = (m_mode == M_RUN) && m_cnt == SS - 1 && inst_valid;
            chk("sys_cnt", 64'(sys_cnt), 64'(m_cnt));
            chk("adr", 64'(adr), 64'(m_adr));
            chk("sync", 64'(sync), 64'(e_sync));
            chk("is", 64'(is), 64'(e_is));
            chk("ws", 64'(ws), 64'(e_ws));
            chk("inst_ready", 64'(inst_ready), 64'(e_rdy));
            chk("underrun", 64'(underrun), 64'(m_under));
        end
    end

    task automatic cyc();
        @(posedge cph2);
        @(negedge cph2);
        #2;
    endtask

    task automatic wait_cnt(input int t);
        int n = 0;
        while (sys_cnt != 6'(t) && n < 200) begin
            cyc();
            n++;
        end
        if (n >= 200) chk("wait_cnt timeout", 64'(sys_cnt), 64'(t));
    endtask

    task automatic pulse_reset();
        run = 0; rstb = 0;
        cyc(); cyc();
        rstb = 1;
    endtask

    // Holds the given inputs for one full word cycle starting at sys_cnt=0.
    task automatic do_word(input logic v, input logic [9:0] d, input logic [3:0] f,
                           input logic [3:0] l, input logic ld, input logic [7:0] ai,
                           output logic [9:0] isb, output logic [63:0] syncm,
                           output logic [63:0] wsm, output int rdy);
        inst_valid = v; inst_data = d; ws_first = f; ws_last = l;
        adr_load = ld; adr_in = ai;
        isb = '0; syncm = '0; wsm = '0; rdy = 0;
        chk("word start cnt", 64'(sys_cnt), 64'd0);
        for (int i = 0; i < WT; i++) begin
            if (sync) syncm[i] = 1'b1;
            if (ws) wsm[i] = 1'b1;
            if (inst_ready) rdy++;
            if (i >= SS && i <= SS + 9) isb[i - SS] = is;
            cyc();
        end
        adr_load = 0;
    endtask

    logic [9:0]  isb;
    logic [63:0] syncm, wsm;
    int          rdy;
    bit          seen_last;

    initial begin
        rstb = 1; run = 0; inst_data = '0; inst_valid = 0;
        ws_first = '0; ws_last = '0; adr_load = 0; adr_in = '0;
        #1 rstb = 0;
        cyc(); cyc();
        rstb = 1;
        chk_en = 1;

        chk("reset sys_cnt", 64'(sys_cnt), 64'd0);
        chk("reset adr", 64'(adr), 64'd0);
        chk("reset sync/is/ws", 64'({sync, is, ws}), 64'd0);
        chk("reset ready/underrun", 64'({inst_ready, underrun}), 64'd0);

        run = 1;
        cyc();
        do_word(1, 10'b1110101000, 4'd2, 4'd4, 0, 8'h00, isb, syncm, wsm, rdy);
        chk("W1 is bits", 64'(isb), 64'b1110101000);
        chk("W1 sync mask", syncm, 64'h007F_E000_0000_0000);
        chk("W1 ws mask", wsm, 64'd0);
        chk("W1 ready", 64'(rdy), 64'd1);
        chk("W1 adr", 64'(adr), 64'h01);

        do_word(1, 10'h2A5, 4'd5, 4'd3, 0, 8'h00, isb, syncm, wsm, rdy);
        chk("W2 ws 2..4", wsm, 64'h0000_0000_000F_FF00);
        chk("W2 is bits", 64'(isb), 64'h2A5);

        do_word(0, 10'h3FF, 4'd2, 4'd4, 0, 8'h00, isb, syncm, wsm, rdy);
        chk("W3 ws reversed", wsm, 64'd0);
        chk("W3 NOP is", 64'(isb), 64'd0);
        chk("W3 ready", 64'(rdy), 64'd0);
        chk("W3 underrun", 64'(underrun), 64'd1);
        chk("W3 adr", 64'(adr), 64'h03);

        do_word(1, 10'h155, 4'd0, 4'd13, 1, 8'h20, isb, syncm, wsm, rdy);
        chk("W4 ws after underrun", wsm, 64'd0);
        chk("W4 adr branch", 64'(adr), 64'h20);
        do_word(1, 10'h0F0, 4'd0, 4'd0, 1, 8'hFF, isb, syncm, wsm, rdy);
        chk("W5 ws full", wsm, 64'h00FF_FFFF_FFFF_FFFF);
        chk("W5 adr", 64'(adr), 64'hFF);
        do_word(1, 10'h00F, 4'd0, 4'd0, 0, 8'h00, isb, syncm, wsm, rdy);
        chk("W6 adr wrap", 64'(adr), 64'h00);
        chk("W6 ws digit0", wsm, 64'h0000_0000_0000_000F);
        chk("underrun sticky", 64'(underrun), 64'd1);

        for (int k = 0; k < 3000; k++) begin
            if (run) run = ($urandom_range(0, 63) != 0);
            else     run = ($urandom_range(0, 7) == 0);
            inst_valid = ($urandom_range(0, 9) != 0);
            inst_data  = 10'($urandom);
            ws_first   = 4'($urandom_range(0, 15));
            ws_last    = 4'($urandom_range(0, 15));
            adr_load   = ($urandom_range(0, 3) == 0);
            adr_in     = 8'($urandom);
            cyc();
        end
        adr_load = 0;

        pulse_reset();
        run = 1; inst_valid = 1; inst_data = 10'h3C3;
        cyc();
        wait_cnt(10);
        run = 0;
        rdy = 0; syncm = '0; seen_last = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (inst_ready) rdy++;
            if (sync) syncm[sys_cnt] = 1'b1;
            if (sys_cnt == 6'(WT - 1)) seen_last = 1;
        end
        chk("drain ready", 64'(rdy), 64'd0);
        chk("drain sync mask", syncm, 64'h007F_E000_0000_0000);
        chk("drain reached 55", 64'(seen_last), 64'd1);
        chk("drain idle cnt", 64'(sys_cnt), 64'd0);

        pulse_reset();
        run = 1; inst_valid = 1; inst_data = 10'h3FF; ws_first = 4'd0; ws_last = 4'd13;
        cyc();
        wait_cnt(WT - 1);
        cyc();
        wait_cnt(48);
        chk("pre-reset sync/is/ws", 64'({sync, is, ws}), 64'b111);
        chk("pre-reset adr", 64'(adr), 64'h01);
        #1 rstb = 0;
        #1;
        chk("async reset sync/is/ws", 64'({sync, is, ws}), 64'd0);
        chk("async reset sys_cnt", 64'(sys_cnt), 64'd0);
        chk("async reset adr", 64'(adr), 64'd0);
        cyc();
        rstb = 1;
        cyc();
        chk("restart cnt0", 64'(sys_cnt), 64'd0);
        cyc();
        chk("restart cnt1", 64'(sys_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
